// File: rtl/oam_dma.sv
// OAM DMA engine: snoops CPU writes to REG_ADDRESS, halts the CPU, then copies
// LENGTH bytes from page {page,00..} to TARGET_ADDRESS, one read/write pair per
// byte, with every state change paced by the CPU-cycle strobe.
// Optional build macro: OAM_DMA_ALIGN_EN adds the one-strobe ALIGN state that is
// inserted after HALT when the transfer starts on an odd CPU cycle.
module oam_dma #(
    parameter logic [15:0] REG_ADDRESS    = 16'h4014,
    parameter logic [15:0] TARGET_ADDRESS = 16'h2004,
    parameter int unsigned LENGTH         = 256
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        cycle_strobe_i,
    input  logic [15:0] cpu_address_i,
    input  logic [7:0]  cpu_data_i,
    input  logic        cpu_write_i,
    input  logic [7:0]  data_i,
    input  logic        data_valid_i,
    output logic        cpu_halt_o,
    output logic [15:0] address_o,
    output logic [7:0]  data_o,
    output logic        read_o,
    output logic        write_o
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HALT  = 3'd1,
        ST_ALIGN = 3'd2,
        ST_READ  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    // index is 8 bits, so LENGTH=256 ends at 8'hFF without ever wrapping
    localparam logic [7:0] LAST_INDEX = 8'(LENGTH - 1);

    state_t      state_q, state_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  index_q, index_d;
    logic [7:0]  byte_q, byte_d;
    logic        have_byte_q, have_byte_d;
    logic        cpu_halt_q, cpu_halt_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [15:0] address_q, address_d;
    logic [7:0]  data_q, data_d;
    logic        take_align;
    logic        trigger;

`ifdef OAM_DMA_ALIGN_EN
    logic parity_q, parity_d;

    // CPU-cycle parity; parity_d already counts the current strobe, so the
    // value seen on the HALT-exit strobe equals the parity of the trigger strobe
    always_comb begin
        parity_d   = cycle_strobe_i ? ~parity_q : parity_q;
        take_align = parity_d;
    end
`else
    // Without alignment support the HALT state always proceeds straight to READ
    always_comb begin
        take_align = 1'b0;
    end
`endif

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        index_d     = index_q;
        byte_d      = byte_q;
        have_byte_d = have_byte_q;
        trigger     = cycle_strobe_i && cpu_write_i && (cpu_address_i == REG_ADDRESS);

        case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    page_d  = cpu_data_i;
                    index_d = 8'd0;
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (cycle_strobe_i) begin
                    state_d = take_align ? ST_ALIGN : ST_READ;
                end
            end
            ST_ALIGN: begin
                if (cycle_strobe_i) begin
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                // The bus may answer on any clock; a same-clock answer still
                // counts toward leaving READ on this strobe.
                if (data_valid_i) begin
                    byte_d      = data_i;
                    have_byte_d = 1'b1;
                end
                if (cycle_strobe_i && (have_byte_q || data_valid_i)) begin
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                have_byte_d = 1'b0;
                if (cycle_strobe_i) begin
                    if (index_q == LAST_INDEX) begin
                        state_d = ST_IDLE;
                    end else begin
                        index_d = index_q + 8'd1;
                        state_d = ST_READ;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are derived from the next state so they are registered yet
        // line up with the state the engine is in
        cpu_halt_d = (state_d != ST_IDLE);
        read_d     = (state_d == ST_READ);
        write_d    = (state_d == ST_WRITE);
        address_d  = 16'd0;
        data_d     = 8'd0;
        if (state_d == ST_READ) begin
            address_d = {page_d, index_d};
        end else if (state_d == ST_WRITE) begin
            address_d = TARGET_ADDRESS;
            data_d    = byte_d;
        end
    end

    // State and output registers; reset overrides any trigger or strobe
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            page_q      <= 8'd0;
            index_q     <= 8'd0;
            byte_q      <= 8'd0;
            have_byte_q <= 1'b0;
            cpu_halt_q  <= 1'b0;
            read_q      <= 1'b0;
            write_q     <= 1'b0;
            address_q   <= 16'd0;
            data_q      <= 8'd0;
`ifdef OAM_DMA_ALIGN_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            index_q     <= index_d;
            byte_q      <= byte_d;
            have_byte_q <= have_byte_d;
            cpu_halt_q  <= cpu_halt_d;
            read_q      <= read_d;
            write_q     <= write_d;
            address_q   <= address_d;
            data_q      <= data_d;
`ifdef OAM_DMA_ALIGN_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign cpu_halt_o = cpu_halt_q;
    assign read_o     = read_q;
    assign write_o    = write_q;
    assign address_o  = address_q;
    assign data_o     = data_q;

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: a bus memory answers DMA reads after a
// chosen number of stalled strobes, and a transfer-level model predicts the
// halt window length and the ordered sequence of writes.
`timescale 1ns/1ps
module tb_oam_dma;

    localparam logic [15:0] REG_ADDR = 16'h4014;
    localparam logic [15:0] TGT_ADDR = 16'h2004;
    localparam int          LEN      = 256;

    logic        clock_i = 1'b0;
    logic        reset_i = 1'b1;
    logic        cycle_strobe_i = 1'b0;
    logic [15:0] cpu_address_i = 16'd0;
    logic [7:0]  cpu_data_i = 8'd0;
    logic        cpu_write_i = 1'b0;
    logic [7:0]  data_i = 8'd0;
    logic        data_valid_i = 1'b0;
    logic        cpu_halt_o;
    logic [15:0] address_o;
    logic [7:0]  data_o;
    logic        read_o;
    logic        write_o;

    oam_dma #(
        .REG_ADDRESS   (REG_ADDR),
        .TARGET_ADDRESS(TGT_ADDR),
        .LENGTH        (LEN)
    ) dut (
        .clock_i       (clock_i),
        .reset_i       (reset_i),
        .cycle_strobe_i(cycle_strobe_i),
        .cpu_address_i (cpu_address_i),
        .cpu_data_i    (cpu_data_i),
        .cpu_write_i   (cpu_write_i),
        .data_i        (data_i),
        .data_valid_i  (data_valid_i),
        .cpu_halt_o    (cpu_halt_o),
        .address_o     (address_o),
        .data_o        (data_o),
        .read_o        (read_o),
        .write_o       (write_o)
    );

    always #5 clock_i = ~clock_i;

    // bus memory and per-byte stall plan
    logic [7:0] mem [0:65535];
    int         k_arr [0:255];

    // model state
    int         n_vec = 0;
    int         n_bad = 0;
    int         period = 2;
    int         phase = 0;
    int         strobe_cnt = 0;
    bit         halt_exp = 0;
    int         halt_left = 0;
    int         exp_total = 0;
    int         dut_halt_cnt = 0;
    logic [7:0] page_m = 8'd0;
    int         cur_idx = 0;
    int         kk = 0;
    int         passed = 0;
    bit         given = 0;
    bit         prev_read = 0;
    bit         prev_write = 0;

    // pending requests for the driver
    bit         req_reset = 0;
    bit         req_wr = 0;
    bit         req_we = 0;
    logic [15:0] req_addr = 16'd0;
    logic [7:0]  req_data = 8'd0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // one clock: sample outputs at the falling edge, check, then drive inputs
    task automatic step();
        bit         stb;
        bit         busy;
        int         align;
        logic [7:0] idx8;
        @(negedge clock_i);
        idx8 = 8'(cur_idx);

        check_val("halt", 32'(cpu_halt_o), 32'(halt_exp));
        check_val("rw_excl", 32'(read_o & write_o), 32'd0);
        if (!read_o && !write_o) begin
            check_val("idle_addr", 32'(address_o), 32'd0);
            check_val("idle_data", 32'(data_o), 32'd0);
        end
        if (read_o) begin
            if (!prev_read) begin
                kk     = (cur_idx < LEN) ? k_arr[cur_idx] : 0;
                passed = 0;
                given  = 0;
            end
            check_val("rd_addr", 32'(address_o), 32'({page_m, idx8}));
        end
        if (write_o) begin
            check_val("wr_addr", 32'(address_o), 32'(TGT_ADDR));
            if (!prev_write) begin
                check_val("wr_data", 32'(data_o), 32'(mem[{page_m, idx8}]));
                $display("write idx=%0d addr=%h data=%h", cur_idx, address_o, data_o);
                cur_idx++;
            end
        end

        // default drive, with CPU-bus noise on non-strobe clocks
        reset_i        = 1'b0;
        cycle_strobe_i = 1'b0;
        cpu_write_i    = 1'($urandom);
        cpu_address_i  = ($urandom_range(0, 3) == 0) ? REG_ADDR : 16'($urandom);
        cpu_data_i     = 8'($urandom);
        data_valid_i   = 1'b0;
        data_i         = 8'($urandom);
        stb            = (phase >= period - 1);
        phase          = stb ? 0 : phase + 1;
        busy           = halt_exp;
        if (stb) begin
            cycle_strobe_i = 1'b1;
            cpu_write_i    = 1'b0;
        end

        if (req_reset) begin
            req_reset = 0;
            reset_i   = 1'b1;
            if (stb) begin
                cpu_write_i   = 1'b1;
                cpu_address_i = REG_ADDR;
            end
            halt_exp   = 0;
            halt_left  = 0;
            strobe_cnt = 0;
            cur_idx    = 0;
        end else begin
            if (stb && cpu_halt_o) dut_halt_cnt++;
            if (stb && busy) begin
                halt_left--;
                if (halt_left == 0) begin
                    halt_exp = 0;
                    check_val("n_writes", 32'(cur_idx), 32'(LEN));
                end
            end
            if (stb && req_wr) begin
                req_wr        = 0;
                cpu_write_i   = req_we;
                cpu_address_i = req_addr;
                cpu_data_i    = req_data;
                if (req_we && req_addr == REG_ADDR && !busy) begin
                    page_m  = req_data;
                    cur_idx = 0;
                    align   = 0;
`ifdef OAM_DMA_ALIGN_EN
                    align = strobe_cnt % 2;
`endif
                    exp_total = 1 + align + LEN;
                    for (int i = 0; i < LEN; i++) exp_total += k_arr[i] + 1;
                    halt_left = exp_total;
                    halt_exp  = 1;
                    $display("trigger page=%h parity=%0d expected_halt_strobes=%0d", req_data, strobe_cnt % 2, exp_total);
                end
            end
            if (stb) strobe_cnt++;
        end

        // bus memory: answer after kk stalled strobes; noise while not reading
        if (read_o && !given && passed == kk) begin
            data_valid_i = 1'b1;
            data_i       = mem[address_o];
            given        = 1;
        end else if (!read_o) begin
            data_valid_i = 1'($urandom);
        end
        if (stb && read_o) passed++;
        prev_read  = read_o;
        prev_write = write_o;
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] d, input bit we);
        req_addr = a;
        req_data = d;
        req_we   = we;
        req_wr   = 1;
        for (int i = 0; i < 64 && req_wr; i++) step();
        if (req_wr) begin
            check_val("issue_timeout", 32'd1, 32'd0);
            req_wr = 0;
        end
    endtask

    task automatic wait_done();
        int b;
        b = 0;
        while (halt_exp && b < 20000) begin
            step();
            b++;
        end
        if (halt_exp) check_val("done_timeout", 32'd1, 32'd0);
        step();
        step();
        check_val("halt_strobes", 32'(dut_halt_cnt), 32'(exp_total));
    endtask

    // walk the strobe counter so the next strobe has the requested parity
    task automatic align_parity(input int want);
        for (int i = 0; i < 64 && (strobe_cnt % 2) != want; i++) step();
    endtask

    initial begin
        int b;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) k_arr[i] = 0;

        // reset
        req_reset = 1;
        step();
        step();
        check_val("rst_halt", 32'(cpu_halt_o), 32'd0);
        check_val("rst_read", 32'(read_o), 32'd0);
        check_val("rst_write", 32'(write_o), 32'd0);
        repeat (5) step();

        // non-trigger accesses: wrong address, and a read of the register
        issue(16'h4015, 8'h02, 1);
        issue(REG_ADDR, 8'h02, 0);
        repeat (20) step();
        check_val("no_trigger", 32'(cpu_halt_o), 32'd0);

        // page 02, data on every READ clock, even-parity trigger
        period = 2;
        phase  = 0;
        align_parity(0);
        dut_halt_cnt = 0;
        issue(REG_ADDR, 8'h02, 1);
        wait_done();
        check_val("halt_513", 32'(dut_halt_cnt), 32'd513);

        // stall index 3 for five strobes and poke the register mid-transfer
        k_arr[3] = 5;
        align_parity(1);
        dut_halt_cnt = 0;
        issue(REG_ADDR, 8'h02, 1);
        repeat (40) step();
        issue(REG_ADDR, 8'h05, 1);
        wait_done();
        k_arr[3] = 0;

        // randomized transfers over strobe rate, stalls, page and parity
        for (int t = 0; t < 3; t++) begin
            period = $urandom_range(1, 4);
            phase  = 0;
            for (int i = 0; i < 256; i++) k_arr[i] = $urandom_range(0, 2);
            align_parity(t % 2);
            dut_halt_cnt = 0;
            issue(REG_ADDR, 8'($urandom), 1);
            repeat ($urandom_range(10, 60)) step();
            issue(REG_ADDR, 8'($urandom), 1);
            wait_done();
        end

        // reset while reading index 100, then a fresh transfer
        period = 2;
        phase  = 0;
        for (int i = 0; i < 256; i++) k_arr[i] = $urandom_range(0, 1);
        issue(REG_ADDR, 8'h7A, 1);
        b = 0;
        while (!(read_o && cur_idx == 100) && b < 5000) begin
            step();
            b++;
        end
        check_val("reach_idx100", 32'(read_o && cur_idx == 100), 32'd1);
        req_reset = 1;
        step();
        step();
        check_val("mid_rst_halt", 32'(cpu_halt_o), 32'd0);
        check_val("mid_rst_read", 32'(read_o), 32'd0);
        check_val("mid_rst_write", 32'(write_o), 32'd0);
        repeat (6) step();
        dut_halt_cnt = 0;
        issue(REG_ADDR, 8'h3C, 1);
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
